ysyx_22041461_mem: RTL and testbench

YSYX_22041461_MEM -- requirements
Module: ysyx_22041461_MEM

---
 rtl/ysyx_22041461_mem.sv | 152 +++++++++++++++
 tb/tb_ysyx_22041461_mem.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041461_mem.sv
// MEM stage: one outstanding load/store on a 64-bit data bus,
// with lane shifting, byte masks and load extension.
module ysyx_22041461_mem (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_valid_in,
    input  logic [63:0] MEM_EXE_in,
    input  logic [63:0] MEM_rs2_in,
    input  logic [3:0]  MEM_ctrl_in,
    input  logic        MEM_ready_in,
    output logic        mem_req,
    output logic        mem_wen,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic        mem_rsp_valid,
    input  logic [63:0] mem_rdata,
    output logic [63:0] MEM_data_out,
    output logic        MEM_valid_out,
    output logic        MEM_stall_req
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LW  = 4'd3;
    localparam logic [3:0] OP_LD  = 4'd4;
    localparam logic [3:0] OP_LBU = 4'd5;
    localparam logic [3:0] OP_LHU = 4'd6;
    localparam logic [3:0] OP_LWU = 4'd7;
    localparam logic [3:0] OP_SB  = 4'd8;
    localparam logic [3:0] OP_SH  = 4'd9;
    localparam logic [3:0] OP_SW  = 4'd10;
    localparam logic [3:0] OP_SD  = 4'd11;

    state_t      state;
    state_t      state_n;
    logic [63:0] addr_q;
    logic [3:0]  op_q;
    logic [63:0] data_q;
    logic [63:0] result_q;

    logic        op_real;
    logic        capture;
    logic        complete;
    logic        is_store;
    logic [5:0]  shamt;
    logic [63:0] field;
    logic [63:0] load_ext;
    logic [7:0]  mask_base;
    logic [7:0]  mask_lane;

    assign op_real  = (MEM_ctrl_in != 4'd0) && (MEM_ctrl_in <= OP_SD);
    assign capture  = (state == IDLE) && MEM_valid_in && op_real;
    assign complete = (state == BUSY) && mem_rsp_valid;
    assign is_store = op_q[3];
    assign shamt    = {addr_q[2:0], 3'b000};
    assign field    = mem_rdata >> shamt;

    always_comb begin
        load_ext = field;
        unique case (op_q)
            OP_LB:   load_ext = {{56{field[7]}}, field[7:0]};
            OP_LH:   load_ext = {{48{field[15]}}, field[15:0]};
            OP_LW:   load_ext = {{32{field[31]}}, field[31:0]};
            OP_LBU:  load_ext = {56'd0, field[7:0]};
            OP_LHU:  load_ext = {48'd0, field[15:0]};
            OP_LWU:  load_ext = {32'd0, field[31:0]};
            default: load_ext = field;
        endcase
    end

    always_comb begin
        mask_base = 8'h00;
        unique case (op_q)
            OP_SB:   mask_base = 8'h01;
            OP_SH:   mask_base = 8'h03;
            OP_SW:   mask_base = 8'h0F;
            OP_SD:   mask_base = 8'hFF;
            default: mask_base = 8'h00;
        endcase
    end

    // Lanes beyond byte 7 fall off the 8-bit result.
    assign mask_lane = mask_base << addr_q[2:0];
    assign mem_addr  = {addr_q[63:3], 3'b000};
    assign mem_wdata = data_q << shamt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            addr_q   <= 64'd0;
            op_q     <= 4'd0;
            data_q   <= 64'd0;
            result_q <= 64'd0;
        end else begin
            state <= state_n;
            if (capture) begin
                addr_q <= MEM_EXE_in;
                op_q   <= MEM_ctrl_in;
                data_q <= MEM_rs2_in;
            end
            if (complete) begin
                result_q <= is_store ? 64'd0 : load_ext;
            end
        end
    end

    always_comb begin
        state_n       = state;
        mem_req       = 1'b0;
        mem_wen       = 1'b0;
        mem_wmask     = 8'h00;
        MEM_data_out  = 64'd0;
        MEM_valid_out = 1'b0;
        MEM_stall_req = 1'b0;
        unique case (state)
            IDLE: begin
                if (capture) begin
                    state_n       = BUSY;
                    MEM_stall_req = rst;
                end else begin
                    MEM_valid_out = MEM_valid_in & rst;
                end
            end
            BUSY: begin
                mem_req       = 1'b1;
                mem_wen       = is_store;
                mem_wmask     = is_store ? mask_lane : 8'h00;
                MEM_stall_req = 1'b1;
                if (mem_rsp_valid) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                MEM_valid_out = 1'b1;
                MEM_data_out  = result_q;
                MEM_stall_req = !MEM_ready_in;
                if (MEM_ready_in) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ysyx_22041461_mem.sv
// Randomized bench for the MEM stage against a byte-level
// reference model of the bus and load/store semantics.
module tb_ysyx_22041461_mem;

    logic        clk;
    logic        rst;
    logic        MEM_valid_in;
    logic [63:0] MEM_EXE_in;
    logic [63:0] MEM_rs2_in;
    logic [3:0]  MEM_ctrl_in;
    logic        MEM_ready_in;
    logic        mem_req;
    logic        mem_wen;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_rsp_valid;
    logic [63:0] mem_rdata;
    logic [63:0] MEM_data_out;
    logic        MEM_valid_out;
    logic        MEM_stall_req;

    int checks;
    int errors;

    ysyx_22041461_mem dut (
        .clk           (clk),
        .rst           (rst),
        .MEM_valid_in  (MEM_valid_in),
        .MEM_EXE_in    (MEM_EXE_in),
        .MEM_rs2_in    (MEM_rs2_in),
        .MEM_ctrl_in   (MEM_ctrl_in),
        .MEM_ready_in  (MEM_ready_in),
        .mem_req       (mem_req),
        .mem_wen       (mem_wen),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wmask     (mem_wmask),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rdata     (mem_rdata),
        .MEM_data_out  (MEM_data_out),
        .MEM_valid_out (MEM_valid_out),
        .MEM_stall_req (MEM_stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int op_size(input logic [3:0] op);
        case (op)
            4'd1, 4'd5, 4'd8: return 1;
            4'd2, 4'd6, 4'd9: return 2;
            4'd3, 4'd7, 4'd10: return 4;
            default: return 8;
        endcase
    endfunction

    function automatic bit op_signed(input logic [3:0] op);
        return (op == 4'd1) || (op == 4'd2) || (op == 4'd3);
    endfunction

    function automatic logic [63:0] ref_wdata(input logic [63:0] a,
                                              input logic [63:0] d);
        logic [63:0] w;
        int k;
        w = 64'd0;
        k = int'(a[2:0]);
        for (int i = 0; i < 8; i++)
            if (k + i < 8) w[(k+i)*8 +: 8] = d[i*8 +: 8];
        return w;
    endfunction

    function automatic logic [7:0] ref_wmask(input logic [3:0] op,
                                             input logic [63:0] a);
        logic [7:0] m;
        int k;
        m = 8'h00;
        k = int'(a[2:0]);
        for (int i = 0; i < op_size(op); i++)
            if (k + i < 8) m[k+i] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] ref_load(input logic [3:0] op,
                                             input logic [63:0] a,
                                             input logic [63:0] rd);
        logic [63:0] v;
        int k;
        int n;
        v = 64'd0;
        k = int'(a[2:0]);
        n = op_size(op);
        for (int i = 0; i < n; i++)
            if (k + i < 8) v[i*8 +: 8] = rd[(k+i)*8 +: 8];
        if (n < 8 && op_signed(op) && v[n*8-1])
            for (int b = n * 8; b < 64; b++) v[b] = 1'b1;
        return v;
    endfunction

    task automatic run_op(input logic vld, input logic [3:0] op,
                          input logic [63:0] a, input logic [63:0] d,
                          input logic [63:0] rd, input int dly,
                          input int rdy_dly);
        bit is_real;
        bit st;
        logic [63:0] res;
        is_real = vld && op != 4'd0 && op <= 4'd11;
        st = op[3];
        res = st ? 64'd0 : ref_load(op, a, rd);
        @(negedge clk);
        MEM_valid_in = vld;
        MEM_ctrl_in = op;
        MEM_EXE_in = a;
        MEM_rs2_in = d;
        MEM_ready_in = 1'b1;
        mem_rsp_valid = 1'b0;
        #1;
        if (!is_real) begin
            check("idle_valid", {63'd0, MEM_valid_out}, {63'd0, vld});
            check("idle_data", MEM_data_out, 64'd0);
            check("idle_stall", {63'd0, MEM_stall_req}, 64'd0);
            check("idle_req", {63'd0, mem_req}, 64'd0);
            return;
        end
        check("acc_stall", {63'd0, MEM_stall_req}, 64'd1);
        check("acc_req", {63'd0, mem_req}, 64'd0);
        check("acc_valid", {63'd0, MEM_valid_out}, 64'd0);
        for (int c = 0; c <= dly; c++) begin
            @(negedge clk);
            MEM_valid_in = 1'($urandom);
            MEM_ctrl_in = 4'($urandom);
            MEM_EXE_in = {$urandom, $urandom};
            MEM_rs2_in = {$urandom, $urandom};
            mem_rsp_valid = (c == dly);
            mem_rdata = (c == dly) ? rd : {$urandom, $urandom};
            #1;
            check("busy_req", {63'd0, mem_req}, 64'd1);
            check("busy_addr", mem_addr, a & ~64'h7);
            check("busy_wen", {63'd0, mem_wen}, {63'd0, st});
            check("busy_stall", {63'd0, MEM_stall_req}, 64'd1);
            check("busy_valid", {63'd0, MEM_valid_out}, 64'd0);
            if (st) begin
                check("busy_wdata", mem_wdata, ref_wdata(a, d));
                check("busy_wmask", {56'd0, mem_wmask},
                      {56'd0, ref_wmask(op, a)});
            end else begin
                check("busy_wmask", {56'd0, mem_wmask}, 64'd0);
            end
        end
        for (int r = 0; r <= rdy_dly; r++) begin
            @(negedge clk);
            MEM_ready_in = (r == rdy_dly);
            mem_rsp_valid = 1'($urandom);
            mem_rdata = {$urandom, $urandom};
            #1;
            check("done_valid", {63'd0, MEM_valid_out}, 64'd1);
            check("done_data", MEM_data_out, res);
            check("done_stall", {63'd0, MEM_stall_req},
                  {63'd0, r != rdy_dly});
            check("done_req", {63'd0, mem_req}, 64'd0);
            check("done_wmask", {56'd0, mem_wmask}, 64'd0);
        end
        @(negedge clk);
        MEM_valid_in = 1'b0;
        mem_rsp_valid = 1'b0;
        #1;
        check("back_valid", {63'd0, MEM_valid_out}, 64'd0);
        check("back_stall", {63'd0, MEM_stall_req}, 64'd0);
        check("back_req", {63'd0, mem_req}, 64'd0);
    endtask

    initial begin
        logic [3:0] op;
        logic vld;
        checks = 0;
        errors = 0;
        rst = 1'b0;
        MEM_valid_in = 1'b0;
        MEM_ctrl_in = 4'd0;
        MEM_EXE_in = 64'd0;
        MEM_rs2_in = 64'd0;
        MEM_ready_in = 1'b1;
        mem_rsp_valid = 1'b0;
        mem_rdata = 64'd0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req", {63'd0, mem_req}, 64'd0);
        check("rst_valid", {63'd0, MEM_valid_out}, 64'd0);
        check("rst_data", MEM_data_out, 64'd0);
        check("rst_wmask", {56'd0, mem_wmask}, 64'd0);
        check("rst_addr", mem_addr, 64'd0);
        #2 rst = 1'b1;

        run_op(1'b1, 4'd1, 64'h8000_0003, 64'd0,
               64'h0000_0000_8000_0000, 0, 0);
        run_op(1'b1, 4'd9, 64'h8000_0006, 64'h1234,
               64'd0, 0, 0);
        run_op(1'b1, 4'd7, 64'h8000_0004, 64'd0,
               64'hDEAD_BEEF_0000_0000, 5, 0);
        run_op(1'b1, 4'd4, 64'h8000_0010, 64'd0,
               64'h0123_4567_89AB_CDEF, 1, 3);
        run_op(1'b1, 4'd0, 64'h0, 64'd0, 64'd0, 0, 0);
        run_op(1'b1, 4'd14, 64'h0, 64'd0, 64'd0, 0, 0);
        run_op(1'b1, 4'd11, 64'h8000_0005,
               64'h1122_3344_5566_7788, 64'd0, 2, 1);

        @(negedge clk);
        MEM_valid_in = 1'b1;
        MEM_ctrl_in = 4'd4;
        MEM_EXE_in = 64'h8000_0040;
        #1;
        check("ar_acc", {63'd0, MEM_stall_req}, 64'd1);
        @(negedge clk);
        MEM_ctrl_in = 4'd0;
        #1;
        check("ar_busy", {63'd0, mem_req}, 64'd1);
        #2 rst = 1'b0;
        #1;
        check("ar_req", {63'd0, mem_req}, 64'd0);
        check("ar_valid", {63'd0, MEM_valid_out}, 64'd0);
        check("ar_data", MEM_data_out, 64'd0);
        @(negedge clk);
        MEM_valid_in = 1'b0;
        #2 rst = 1'b1;
        @(negedge clk);
        mem_rsp_valid = 1'b1;
        mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        check("late_req", {63'd0, mem_req}, 64'd0);
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        #1;
        check("late_valid", {63'd0, MEM_valid_out}, 64'd0);
        check("late_stall", {63'd0, MEM_stall_req}, 64'd0);
        check("late_data", MEM_data_out, 64'd0);

        for (int t = 0; t < 200; t++) begin
            op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) op = 4'($urandom_range(1, 11));
            vld = ($urandom_range(0, 7) != 0);
            run_op(vld, op, {$urandom, $urandom}, {$urandom, $urandom},
                   {$urandom, $urandom}, $urandom_range(0, 3),
                   $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
